mcu_bus_sync: RTL and testbench
===============================

MCU_BUS_SYNC -- requirements
Module: mcu_bus_sync

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, register address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width; byte lanes are [7:0] and [15:8].
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop depth of each strobe synchronizer; legal range 2..4.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, clk cycles to wait for reg_ack; legal range 1..65535.
REQ-005 SHALL have port clk  in  1  system clock; the block uses one clock only.
REQ-006 SHALL have port reset  in  1  system reset, asynchronous, active-low.
REQ-007 SHALL have ports bus_cs_n, bus_rd_n, bus_wr_n  in  1 each  MCU chip select, read strobe and write strobe, asynchronous, active-low.
REQ-008 SHALL have port bus_be_n  in  2  MCU byte enables, active-low.
REQ-009 SHALL have ports bus_addr  in  ADDR_WIDTH  and bus_wdata  in  DATA_WIDTH  MCU address and write data.
REQ-010 SHALL have ports bus_rdata  out  DATA_WIDTH  and bus_oe  out  1  read data and pad output enable for the external tristate.
REQ-011 SHALL have port bus_wait_n  out  1  MCU wait request, low while an access is pending.
REQ-012 SHALL have ports reg_en, reg_rd, reg_wr  out  1 each, reg_be  out  2, reg_addr  out  ADDR_WIDTH, reg_wdata  out  DATA_WIDTH  register-file request.
REQ-013 SHALL have ports reg_rdata  in  DATA_WIDTH  and reg_ack  in  1  register-file read data and completion.
REQ-014 SHALL have port err_pulse  out  1  one-cycle error indication.

Function
REQ-015 SHALL pass each of cs, rd and wr through a SYNC_STAGES-flop synchronizer before use; the raw strobes feed no other logic.
REQ-016 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-017 In IDLE, synced cs & exactly one of rd/wr active SHALL capture bus_addr, bus_wdata and ~bus_be_n into holding registers and enter REQ on the next edge.
REQ-018 In IDLE, synced cs with rd and wr both active SHALL start no request, pulse err_pulse once, and enter HOLD.
REQ-019 In REQ, reg_en and exactly one of reg_rd/reg_wr SHALL be held high with stable reg_addr/reg_be/reg_wdata until the cycle reg_ack is sampled high.
REQ-020 On reg_ack in REQ: for a read, reg_rdata SHALL be registered into bus_rdata; the FSM SHALL enter HOLD; request outputs SHALL drop the following cycle.
REQ-021 bus_wait_n SHALL be low from the cycle after a valid access is detected until the cycle after the REQ exit, and high otherwise.
REQ-022 bus_oe SHALL be high only in HOLD for a read access while synced rd and cs remain active.
REQ-023 In HOLD, the FSM SHALL return to IDLE when synced cs or the active strobe deasserts; no second request is issued for one strobe.
REQ-024 reg_ack outside REQ SHALL be ignored.
REQ-025 cs deasserting during REQ SHALL not abort the request; the FSM completes REQ and passes through HOLD to IDLE.

Reset
REQ-026 Reset low SHALL asynchronously force IDLE, clear all synchronizer flops, timeout counter and holding registers, and drive reg_*=0, bus_rdata=0, bus_oe=0, err_pulse=0, bus_wait_n=1.
REQ-027 Reset asserted mid-access SHALL discard the access; after release, a strobe still active SHALL be treated as a new access only after passing through IDLE.

Configuration
REQ-028 With macro MCU_BUS_TIMEOUT_EN defined, a counter SHALL run in REQ; on reaching TIMEOUT_CYCLES without reg_ack, the FSM SHALL enter HOLD, load bus_rdata with all ones for reads, and pulse err_pulse once.
REQ-029 Without MCU_BUS_TIMEOUT_EN, REQ SHALL wait indefinitely for reg_ack, no counter SHALL exist, and err_pulse SHALL assert only per REQ-018.

Structure
REQ-030 Shared package mcu_bus_pkg SHALL hold the FSM state encoding, default widths, and the timeout read value constant.
REQ-031 The synchronizer SHALL be sub-module bus_sync_cell (parameter SYNC_STAGES, asynchronous active-low reset), instantiated once per strobe.

Verification
REQ-032 Write addr=0x0012, data=0xBEEF, be_n=2'b00, reg_ack 3 cycles after REQ entry -> one reg_wr request, addr 0x0012, data 0xBEEF, be 2'b11; bus_wait_n low throughout; one request per strobe.
REQ-033 Read addr=0x0004, reg_rdata=0x1234 with reg_ack -> bus_rdata=0x1234, bus_oe high until rd_n rises, then IDLE.
REQ-034 rd_n and wr_n both low under cs_n -> no reg_en, one err_pulse, return to IDLE after strobes release.
REQ-035 With MCU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with no reg_ack -> HOLD after 8 cycles, bus_rdata=0xFFFF, one err_pulse.
REQ-036 Reset pulsed low during REQ -> all outputs at reset values immediately; a held strobe produces a new request only via IDLE after release.

Source files
------------

// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: FSM encoding, default bus widths and timeout read value shared by mcu_bus_sync.
package mcu_bus_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam logic [63:0] TIMEOUT_RDATA = '1;
endpackage

// File: rtl/bus_sync_cell.sv
// bus_sync_cell: SYNC_STAGES-deep flop chain bringing one asynchronous strobe into clk.
module bus_sync_cell #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/mcu_bus_sync.sv
// mcu_bus_sync: bridges an asynchronous MCU strobe bus to a single-clock register-file request.
// Defining MCU_BUS_TIMEOUT_EN adds a reg_ack timeout that ends the access with an error pulse.
module mcu_bus_sync
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_cs_n,
    input  logic                  bus_rd_n,
    input  logic                  bus_wr_n,
    input  logic [1:0]            bus_be_n,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_oe,
    output logic                  bus_wait_n,
    output logic                  reg_en,
    output logic                  reg_rd,
    output logic                  reg_wr,
    output logic [1:0]            reg_be,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack,
    output logic                  err_pulse
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("mcu_bus_sync: SYNC_STAGES or TIMEOUT_CYCLES out of range");
    end

    logic cs_s, rd_s, wr_s, timeout;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0] be_q, be_d;
    logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;

    bus_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .reset(reset), .d_i(~bus_cs_n), .q_o(cs_s));
    bus_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .reset(reset), .d_i(~bus_rd_n), .q_o(rd_s));
    bus_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .reset(reset), .d_i(~bus_wr_n), .q_o(wr_s));

`ifdef MCU_BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d   = (state_q == REQ) ? cnt_q + 16'd1 : '0;
    assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_s && (rd_s ^ wr_s)) begin
                    state_d = REQ;
                    addr_d  = bus_addr;
                    wdata_d = bus_wdata;
                    be_d    = ~bus_be_n;
                    rd_d    = rd_s;
                    wr_d    = wr_s;
                end else if (cs_s && rd_s && wr_s) begin
                    // both strobes held: error access, HOLD waits for both to release
                    state_d = HOLD;
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            REQ: begin
                if (reg_ack) begin
                    state_d = HOLD;
                    rdata_d = rd_q ? reg_rdata : rdata_q;
                end else if (timeout) begin
                    state_d = HOLD;
                    rdata_d = rd_q ? TIMEOUT_RDATA[DATA_WIDTH-1:0] : rdata_q;
                    err_d   = 1'b1;
                end
            end
            HOLD:    state_d = (cs_s && ((rd_q && rd_s) || (wr_q && wr_s))) ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end

    assign reg_en     = state_q == REQ;
    assign reg_rd     = reg_en && rd_q;
    assign reg_wr     = reg_en && wr_q;
    assign reg_be     = be_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign bus_rdata  = rdata_q;
    assign bus_wait_n = state_q != REQ;
    assign bus_oe     = (state_q == HOLD) && rd_q && !wr_q && rd_s && cs_s;
    assign err_pulse  = err_q;
endmodule

// File: tb/tb_mcu_bus_sync.sv
// tb_mcu_bus_sync: scoreboard bench for mcu_bus_sync; expected requests are queued when strobes are driven.
module tb_mcu_bus_sync;
    localparam int SYNC = 2;
    localparam int TO   = 8;

    logic        clk, reset;
    logic        bus_cs_n, bus_rd_n, bus_wr_n;
    logic [1:0]  bus_be_n;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_oe, bus_wait_n;
    logic        reg_en, reg_rd, reg_wr;
    logic [1:0]  reg_be;
    logic [15:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_ack, err_pulse;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } req_t;

    req_t exp_q[$];
    req_t cur;
    int   tests = 0, fails = 0, req_cnt = 0, err_cnt = 0;
    logic en_prev = 1'b0;

    mcu_bus_sync #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_be_n(bus_be_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_oe(bus_oe), .bus_wait_n(bus_wait_n),
        .reg_en(reg_en), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_be(reg_be),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // request monitor: pops the scoreboard on each new request, checks fields every REQ cycle
    always @(negedge clk) begin
        if (reg_en) begin
            if (!en_prev) begin
                req_cnt++;
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            chk("reg_rd", reg_rd, cur.rd);
            chk("reg_wr", reg_wr, !cur.rd);
            chk("reg_addr", reg_addr, cur.addr);
            chk("reg_wdata", reg_wdata, cur.wdata);
            chk("reg_be", reg_be, cur.be);
        end
        if (err_pulse) err_cnt++;
        en_prev = reg_en;
    end

    task automatic wait_req();
        int n = 0;
        while (!reg_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_start", reg_en, 1);
    endtask

    task automatic release_bus();
        bus_cs_n = 1'b1;
        bus_rd_n = 1'b1;
        bus_wr_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic start(input logic rd, input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be_n);
        exp_q.push_back('{rd: rd, addr: addr, wdata: wd, be: ~be_n});
        @(negedge clk);
        bus_addr  = addr;
        bus_wdata = wd;
        bus_be_n  = be_n;
        bus_cs_n  = 1'b0;
        bus_rd_n  = !rd;
        bus_wr_n  = rd;
        wait_req();
    endtask

    task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be_n, input logic [15:0] rv, input int dly, input logic early);
        int r0 = req_cnt;
        start(rd, addr, wd, be_n);
        if (early) bus_cs_n = 1'b1;
        for (int i = 0; i < dly; i++) begin
            chk("wait_low", bus_wait_n, 0);
            @(negedge clk);
        end
        chk("wait_low", bus_wait_n, 0);
        reg_ack   = 1'b1;
        reg_rdata = rv;
        @(negedge clk);
        reg_ack   = 1'b0;
        reg_rdata = 16'h0;
        chk("req_drop", reg_en, 0);
        chk("wait_high", bus_wait_n, 1);
        if (rd) chk("bus_rdata", bus_rdata, rv);
        if (!early) begin
            repeat (3) @(negedge clk);
            chk("bus_oe_hold", bus_oe, rd);
        end
        release_bus();
        chk("bus_oe_idle", bus_oe, 0);
        chk("one_req", req_cnt - r0, 1);
    endtask

    initial begin
        int r0, e0, n;
        reset = 1'b0;
        bus_cs_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
        bus_be_n = 2'b11; bus_addr = '0; bus_wdata = '0;
        reg_rdata = '0; reg_ack = 1'b0;
        #3;
        chk("rst_reg_en", reg_en, 0);
        chk("rst_wait_n", bus_wait_n, 1);
        chk("rst_oe", bus_oe, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_err", err_pulse, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        access(1'b0, 16'h0012, 16'hBEEF, 2'b00, 16'h0000, 3, 1'b0);
        access(1'b1, 16'h0004, 16'h0000, 2'b00, 16'h1234, 1, 1'b0);
        access(1'b0, 16'h0100, 16'h00A5, 2'b10, 16'h0000, 0, 1'b0);

        r0 = req_cnt; e0 = err_cnt;
        @(negedge clk);
        bus_cs_n = 1'b0; bus_rd_n = 1'b0; bus_wr_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("err_no_en", reg_en, 0);
        chk("err_wait_n", bus_wait_n, 1);
        chk("err_oe", bus_oe, 0);
        chk("err_pulses", err_cnt - e0, 1);
        release_bus();
        chk("err_no_req", req_cnt - r0, 0);

        access(1'b1, 16'h0022, 16'h7E7E, 2'b01, 16'h0F0F, 2, 1'b1);

`ifdef MCU_BUS_TIMEOUT_EN
        e0 = err_cnt;
        start(1'b1, 16'h0030, 16'h0000, 2'b00);
        n = 0;
        while (reg_en && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, TO);
        chk("to_rdata", bus_rdata, 16'hFFFF);
        repeat (2) @(negedge clk);
        chk("to_err", err_cnt - e0, 1);
        release_bus();
`else
        e0 = err_cnt;
        access(1'b1, 16'h0008, 16'h0000, 2'b00, 16'hCAFE, 40, 1'b0);
        chk("no_to_err", err_cnt - e0, 0);
`endif

        start(1'b1, 16'h0040, 16'h0000, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_reg_en", reg_en, 0);
        chk("arst_reg_rd", reg_rd, 0);
        chk("arst_reg_addr", reg_addr, 0);
        chk("arst_wait_n", bus_wait_n, 1);
        chk("arst_oe", bus_oe, 0);
        chk("arst_rdata", bus_rdata, 0);
        chk("arst_err", err_pulse, 0);
        @(negedge clk);
        r0 = req_cnt;
        exp_q.push_back('{rd: 1'b1, addr: 16'h0040, wdata: 16'h0000, be: 2'b11});
        reset = 1'b1;
        @(negedge clk);
        chk("rel_no_req", reg_en, 0);
        wait_req();
        reg_ack   = 1'b1;
        reg_rdata = 16'h5A5A;
        @(negedge clk);
        reg_ack   = 1'b0;
        chk("rel_rdata", bus_rdata, 16'h5A5A);
        release_bus();
        chk("rel_one_req", req_cnt - r0, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
